uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, one start bit, DBIT data bits, one stop bit.
// rx is resynchronized; framed bytes appear on d_out with a one-clk rx_done pulse.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | counting to mid start bit, rejecting glitches
// DATA  | sampling DBIT data bits at mid-bit
// STOP  | waiting SB_TICK ticks, then checking the stop bit
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            baud_rate,
  input  logic            rx,
  output logic [DBIT-1:0] d_out,
  output logic            rx_done,
  output logic            frame_err,
  output logic            busy
);

  localparam int              NW      = $clog2(DBIT) + 1;
  localparam logic [3:0]      SB_LAST = 4'(SB_TICK - 1);
  localparam logic [NW-1:0]   N_LAST  = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t          r_state;
  logic [3:0]      r_s_cnt;
  logic [NW-1:0]   r_n_cnt;
  logic [DBIT-1:0] r_shift;
  logic [DBIT-1:0] r_d_out;
  logic            r_rx_done;
  logic            r_frame_err;
  logic            r_rx_meta;
  logic            r_rx_s;

  // Reset to the idle level so a released reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_s_cnt     <= '0;
      r_n_cnt     <= '0;
      r_shift     <= '0;
      r_d_out     <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!r_rx_s) begin
            r_state <= ST_START;
            r_s_cnt <= '0;
          end
        end
        ST_START: begin
          if (baud_rate) begin
            if (r_s_cnt == 4'd7) begin
              if (!r_rx_s) begin
                r_state <= ST_DATA;
                r_s_cnt <= '0;
                r_n_cnt <= '0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_s_cnt <= r_s_cnt + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (baud_rate) begin
            if (r_s_cnt == 4'd15) begin
              r_shift <= {r_rx_s, r_shift[DBIT-1:1]};
              r_s_cnt <= '0;
              r_n_cnt <= r_n_cnt + NW'(1);
              if (r_n_cnt == N_LAST)
                r_state <= ST_STOP;
            end else begin
              r_s_cnt <= r_s_cnt + 4'd1;
            end
          end
        end
        ST_STOP: begin
          if (baud_rate) begin
            if (r_s_cnt == SB_LAST) begin
              r_state <= ST_IDLE;
              if (r_rx_s) begin
                r_d_out   <= r_shift;
                r_rx_done <= 1'b1;
              end else begin
                r_frame_err <= 1'b1;
              end
            end else begin
              r_s_cnt <= r_s_cnt + 4'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign d_out     = r_d_out;
  assign rx_done   = r_rx_done;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial-line driver queues the expected event per frame,
// and a monitor checks every rx_done/frame_err pulse against that queue.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       baud_rate;
  logic       rx;
  logic [7:0] d_out;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_rate (baud_rate),
    .rx        (rx),
    .d_out     (d_out),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] dout;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] model_last;
  int         checks;
  int         failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One tick every 4 clk: one bit is 64 clk at the nominal rate.
  initial begin
    int tcnt;
    tcnt      = 0;
    baud_rate = 1'b0;
    forever begin
      @(negedge clk);
      tcnt      = tcnt + 1;
      baud_rate = (tcnt % 4 == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (rx_done || frame_err)) begin
      chk("pulse_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
      if (sb_q.size() == 0) begin
        checks   = checks + 1;
        failures = failures + 1;
        $display("FAIL unexpected_pulse actual rx_done=%0b frame_err=%0b d_out=%0h required no pulse time=%0t",
                 rx_done, frame_err, d_out, $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pulse_kind", {31'd0, frame_err}, {31'd0, mon_e.is_err});
        chk("d_out", {24'd0, d_out}, {24'd0, mon_e.dout});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected outcome comes from the frame's content alone: a high stop bit delivers the byte,
  // a low stop bit flags an error and leaves the previous byte in place.
  task automatic send_frame(input logic [7:0] data, input int bit_clk, input bit stop_ok, input int gap);
    exp_t e;
    e.is_err = !stop_ok;
    if (stop_ok) model_last = data;
    e.dout = model_last;
    sb_q.push_back(e);
    rx = 1'b0;
    wait_clk(bit_clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      if (i == 4) begin
        wait_clk(bit_clk / 2);
        chk("busy_mid_frame", {31'd0, busy}, 32'd1);
        wait_clk(bit_clk - bit_clk / 2);
      end else begin
        wait_clk(bit_clk);
      end
    end
    if (stop_ok) begin
      rx = 1'b1;
      wait_clk(bit_clk);
    end else begin
      // Low across the stop sample, high again before a re-armed start check would sample.
      rx = 1'b0;
      wait_clk(48);
      rx = 1'b1;
      wait_clk(bit_clk - 48);
    end
    wait_clk(gap);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n = n + 1;
    end
    chk(name, sb_q.size(), 32'd0);
    wait_clk(8);
    chk("busy_idle_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [7:0] b;
    int per;
    bit ok;
    int gap;

    checks     = 0;
    failures   = 0;
    model_last = 8'h00;
    rx         = 1'b1;
    rst_n      = 1'b0;
    wait_clk(6);
    chk("rst_d_out", {24'd0, d_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rx_done", {31'd0, rx_done}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    wait_clk(20);

    send_frame(8'hA5, 64, 1'b1, 64);
    drain("drain_a5");

    send_frame(8'h3C, 64, 1'b1, 0);
    send_frame(8'hFF, 64, 1'b1, 64);
    drain("drain_back_to_back");

    // Short low pulse: start check at mid-bit rejects it.
    rx = 1'b0;
    wait_clk(20);
    rx = 1'b1;
    wait_clk(120);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    chk("glitch_d_out", {24'd0, d_out}, {24'd0, model_last});

    send_frame(8'h55, 64, 1'b0, 80);
    drain("drain_bad_stop");
    chk("bad_stop_d_out", {24'd0, d_out}, {24'd0, model_last});

    // Break: line low across two frame periods gives two frame errors, released before a third start check.
    e.is_err = 1'b1;
    e.dout   = model_last;
    sb_q.push_back(e);
    sb_q.push_back(e);
    rx = 1'b0;
    wait_clk(1240);
    rx = 1'b1;
    wait_clk(200);
    drain("drain_break");

    // Abort 0x81 mid data bit 4 with reset.
    b  = 8'h81;
    rx = 1'b0;
    wait_clk(64);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_clk(64);
    end
    rx = b[4];
    wait_clk(32);
    rst_n = 1'b0;
    rx    = 1'b1;
    wait_clk(1);
    chk("abort_rst_d_out", {24'd0, d_out}, 32'd0);
    chk("abort_rst_busy", {31'd0, busy}, 32'd0);
    wait_clk(5);
    rst_n = 1'b1;
    model_last = 8'h00;
    wait_clk(200);
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    chk("abort_d_out", {24'd0, d_out}, 32'd0);
    send_frame(8'h81, 64, 1'b1, 64);
    drain("drain_81");

    // +/-3% transmitter rate.
    send_frame(8'h00, 66, 1'b1, 64);
    send_frame(8'hFF, 66, 1'b1, 64);
    send_frame(8'h00, 62, 1'b1, 64);
    send_frame(8'hFF, 62, 1'b1, 64);
    drain("drain_mismatch");

    for (int k = 0; k < 24; k++) begin
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 5) != 0);
      if (ok) begin
        case ($urandom_range(0, 2))
          0: per = 62;
          1: per = 64;
          default: per = 66;
        endcase
        gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 100));
      end else begin
        per = 64;
        gap = 80 + int'($urandom_range(0, 40));
      end
      send_frame(b, per, ok, gap);
    end
    drain("drain_random");
    chk("final_d_out", {24'd0, d_out}, {24'd0, model_last});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
